// File: rtl/sram_like_resp.sv
// In-order sram-like responder backed by a word-addressed RAM with a bounded outstanding queue.
// Optional SRAM_RESP_RANDOM_STALL_EN adds LFSR-driven accept/response stalls.
module sram_like_resp #(
    parameter int AW      = 10,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [3:0]    LAT  = 4'(LATENCY);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [31:0]      mem [2**AW];
    logic [AW-1:0]    widx;
    logic             q_wr   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [3:0]       q_age  [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic             acc_stall;
    logic             rsp_stall;
    logic             unused_bits;

    assign widx        = addr[AW+1:2];
    assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

`ifdef SRAM_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign acc_stall = (lfsr[1:0] == 2'b00);
    assign rsp_stall = (lfsr[3:2] == 2'b00);
`else
    assign acc_stall = 1'b0;
    assign rsp_stall = 1'b0;
`endif

    // Depends on queue state only, so masters may sample it combinationally.
    assign addr_ok = resetn & (count < CW'(DEPTH)) & ~acc_stall;
    assign push    = req & addr_ok;
    assign data_ok = (count != '0) & (q_age[head] == LAT) & ~rsp_stall;
    assign pop     = data_ok;
    assign rdata   = (data_ok && !q_wr[head]) ? q_data[head] : 32'h0;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Age counts the acceptance cycle itself, so a new entry lands at 1 and
    // LATENCY = 1 answers in the cycle right after acceptance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_wr[i]   <= 1'b0;
                q_data[i] <= 32'h0;
                q_age[i]  <= 4'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && tail == PW'(i)) begin
                    q_vld[i]  <= 1'b1;
                    q_wr[i]   <= wr;
                    q_data[i] <= wr ? 32'h0 : mem[widx];
                    q_age[i]  <= 4'd1;
                end else if (pop && head == PW'(i)) begin
                    q_vld[i]  <= 1'b0;
                    q_age[i]  <= 4'd0;
                end else if (q_vld[i] && q_age[i] != LAT) begin
                    q_age[i]  <= q_age[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule
